freelist_m: RTL and testbench

//  Free list of physical register tags for the R10K-style rename stage.

---
 rtl/freelist_m_pkg.sv | 46 ++++
 rtl/freelist_m.sv | 76 +++++++
 tb/tb_freelist_m.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/freelist_m_pkg.sv
// Shared rename-stage definitions: register-file sizing, tag/pointer types and
// the free-list packet and state structures.
package freelist_m_pkg;

  localparam int NUM_PR   = 64;
  localparam int NUM_ARCH = 32;
  localparam int NUM_FL   = NUM_PR - NUM_ARCH;
  localparam int PRW      = $clog2(NUM_PR);
  localparam int PTRW     = (NUM_FL > 1) ? $clog2(NUM_FL) : 1;
  localparam int CNTW     = $clog2(NUM_FL + 1);

  typedef logic [PRW-1:0]  pr_tag_t;
  typedef logic [PTRW-1:0] fl_ptr_t;
  typedef logic [CNTW-1:0] fl_cnt_t;

  typedef struct packed {
    logic    dispatch;
    logic    retire;
    pr_tag_t T_old_in;
  } FREELIST_PACKET_IN_t;

  typedef struct packed {
    pr_tag_t T_out;
    logic    T_valid;
    logic    struct_hazard;
    fl_cnt_t free_count;
  } FREELIST_PACKET_OUT_t;

  typedef struct packed {
    fl_ptr_t                head;
    fl_ptr_t                tail;
    fl_cnt_t                count;
    pr_tag_t [NUM_FL-1:0]   entry;
  } FREELIST_t;

  // Power-up image: every non-architectural PR is free, in ascending order.
  function automatic FREELIST_t freelist_init();
    FREELIST_t s;
    s.head  = '0;
    s.tail  = '0;
    s.count = fl_cnt_t'(NUM_FL);
    for (int i = 0; i < NUM_FL; i++) s.entry[i] = pr_tag_t'(NUM_ARCH + i);
    return s;
  endfunction

endpackage

// File: rtl/freelist_m.sv
// Free list of physical register tags: pops a new destination tag at dispatch,
// reclaims T_old at retire. Circular FIFO with explicit (non power-of-2) wrap.
module freelist_m
  import freelist_m_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    en,
  input  logic    dispatch,
  input  logic    retire,
  input  pr_tag_t T_old_in,
  output pr_tag_t T_out,
  output logic    T_valid,
  output logic    struct_hazard,
  output fl_cnt_t free_count,
  output logic    overflow_err
);

  FREELIST_t            fl, fl_next;
  FREELIST_PACKET_IN_t  pkt_in;
  FREELIST_PACKET_OUT_t pkt_out;
  logic                 err, err_next;
  logic                 empty, full, pop, push;

  function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
    return (p == fl_ptr_t'(NUM_FL - 1)) ? '0 : p + fl_ptr_t'(1);
  endfunction

  assign pkt_in = '{dispatch: dispatch, retire: retire, T_old_in: T_old_in};

  assign empty = (fl.count == '0);
  assign full  = (fl.count == fl_cnt_t'(NUM_FL));
  // No bypass: an empty list refuses the pop even when a push lands this cycle.
  assign pop   = en & pkt_in.dispatch & ~empty;
  assign push  = en & pkt_in.retire & ~full;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fl_next  = fl;
    err_next = err | (en & pkt_in.retire & full);
    if (push) begin
      fl_next.entry[fl.tail] = pkt_in.T_old_in;
      fl_next.tail           = ptr_inc(fl.tail);
    end
    if (pop) fl_next.head = ptr_inc(fl.head);
    case ({push, pop})
      2'b10:   fl_next.count = fl.count + fl_cnt_t'(1);
      2'b01:   fl_next.count = fl.count - fl_cnt_t'(1);
      default: fl_next.count = fl.count;
    endcase
  end

  // NOTE: non-blocking assignments here so all state samples pre-edge values together.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the tag storage is reset too, because reset must restore the full initial list.
      fl  <= freelist_init();
      err <= 1'b0;
    end else begin
      fl  <= fl_next;
      err <= err_next;
    end
  end

  assign pkt_out = '{T_out:         fl.entry[fl.head],
                     T_valid:       ~empty,
                     struct_hazard: empty,
                     free_count:    fl.count};

  assign T_out         = pkt_out.T_out;
  assign T_valid       = pkt_out.T_valid;
  assign struct_hazard = pkt_out.struct_hazard;
  assign free_count    = pkt_out.free_count;
  assign overflow_err  = err;

endmodule

// File: tb/tb_freelist_m.sv
// Directed bench for freelist_m: reset image, drain, empty/full corners,
// pointer wrap, global stall and mid-operation reset.
module tb_freelist_m;
  import freelist_m_pkg::*;

  logic    clock, reset, en, dispatch, retire;
  pr_tag_t T_old_in, T_out;
  logic    T_valid, struct_hazard, overflow_err;
  fl_cnt_t free_count;

  int total = 0;
  int bad   = 0;

  freelist_m dut (
    .clock(clock), .reset(reset), .en(en), .dispatch(dispatch), .retire(retire),
    .T_old_in(T_old_in), .T_out(T_out), .T_valid(T_valid),
    .struct_hazard(struct_hazard), .free_count(free_count),
    .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; dispatch = 1'b0; retire = 1'b0; T_old_in = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (T_out !== 6'd32) begin bad++; $display("FAIL reset_T_out got=%0d exp=32", T_out); end
    total++; if (T_valid !== 1'b1) begin bad++; $display("FAIL reset_T_valid got=%0b exp=1", T_valid); end
    total++; if (struct_hazard !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%0b exp=0", struct_hazard); end
    total++; if (free_count !== 6'd32) begin bad++; $display("FAIL reset_count got=%0d exp=32", free_count); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", overflow_err); end
  endtask

  task automatic test_drain();
    do_reset();
    dispatch = 1'b1;
    for (int i = 0; i < 32; i++) begin
      total++;
      if (T_out !== pr_tag_t'(32 + i)) begin bad++; $display("FAIL drain_T_out[%0d] got=%0d exp=%0d", i, T_out, 32 + i); end
      cycle();
    end
    total++; if (T_valid !== 1'b0) begin bad++; $display("FAIL drain_T_valid got=%0b exp=0", T_valid); end
    total++; if (struct_hazard !== 1'b1) begin bad++; $display("FAIL drain_hazard got=%0b exp=1", struct_hazard); end
    total++; if (free_count !== 6'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", free_count); end
    // Dispatch while empty: nothing moves, head has wrapped back onto stale tag 32.
    cycle();
    total++; if (free_count !== 6'd0) begin bad++; $display("FAIL empty_disp_count got=%0d exp=0", free_count); end
    total++; if (T_out !== 6'd32) begin bad++; $display("FAIL empty_disp_T_out got=%0d exp=32", T_out); end
  endtask

  // Runs from the empty state left by test_drain.
  task automatic test_empty_push();
    dispatch = 1'b1; retire = 1'b1; T_old_in = 6'd5;
    cycle();
    idle();
    total++; if (T_out !== 6'd5) begin bad++; $display("FAIL empty_push_T_out got=%0d exp=5", T_out); end
    total++; if (free_count !== 6'd1) begin bad++; $display("FAIL empty_push_count got=%0d exp=1", free_count); end
    total++; if (T_valid !== 1'b1) begin bad++; $display("FAIL empty_push_T_valid got=%0b exp=1", T_valid); end
    cycle();
    total++; if (free_count !== 6'd1) begin bad++; $display("FAIL empty_push_hold got=%0d exp=1", free_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    retire = 1'b1; T_old_in = 6'd7;
    cycle();
    idle();
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0b exp=1", overflow_err); end
    total++; if (free_count !== 6'd32) begin bad++; $display("FAIL ovf_count got=%0d exp=32", free_count); end
    for (int i = 0; i < 10; i++) begin
      cycle();
      total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky[%0d] got=%0b exp=1", i, overflow_err); end
    end
    // Full plus retire with dispatch: pop proceeds, push dropped.
    do_reset();
    dispatch = 1'b1; retire = 1'b1; T_old_in = 6'd9;
    cycle();
    idle();
    total++; if (free_count !== 6'd31) begin bad++; $display("FAIL ovf_pop_count got=%0d exp=31", free_count); end
    total++; if (T_out !== 6'd33) begin bad++; $display("FAIL ovf_pop_T_out got=%0d exp=33", T_out); end
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_pop_err got=%0b exp=1", overflow_err); end
  endtask

  task automatic test_wrap();
    do_reset();
    dispatch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (T_out !== pr_tag_t'(32 + i)) begin bad++; $display("FAIL wrap_pre[%0d] got=%0d exp=%0d", i, T_out, 32 + i); end
      cycle();
    end
    retire = 1'b1;
    for (int k = 0; k < 40; k++) begin
      T_old_in = pr_tag_t'(k);
      total++;
      if (T_out !== pr_tag_t'((k < 29) ? 35 + k : k - 29)) begin
        bad++; $display("FAIL wrap_T_out[%0d] got=%0d exp=%0d", k, T_out, (k < 29) ? 35 + k : k - 29);
      end
      cycle();
      total++; if (free_count !== 6'd29) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=29", k, free_count); end
    end
    idle();
    total++; if (T_out !== 6'd11) begin bad++; $display("FAIL wrap_final got=%0d exp=11", T_out); end
  endtask

  // Runs from the state left by test_wrap: T_out=11, count=29, err=0.
  task automatic test_stall();
    en = 1'b0; dispatch = 1'b1; retire = 1'b1; T_old_in = 6'd50;
    for (int i = 0; i < 5; i++) begin
      cycle();
      total++; if (T_out !== 6'd11) begin bad++; $display("FAIL stall_T_out[%0d] got=%0d exp=11", i, T_out); end
      total++; if (free_count !== 6'd29) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=29", i, free_count); end
      total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL stall_err[%0d] got=%0b exp=0", i, overflow_err); end
    end
    // Stalled retire into a full list must not raise the error.
    do_reset();
    en = 1'b0; retire = 1'b1; T_old_in = 6'd3;
    cycle();
    idle();
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL stall_full_err got=%0b exp=0", overflow_err); end
    total++; if (free_count !== 6'd32) begin bad++; $display("FAIL stall_full_count got=%0d exp=32", free_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dispatch = 1'b1;
    repeat (10) cycle();
    idle();
    retire = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      T_old_in = pr_tag_t'(i);
      cycle();
    end
    total++; if (free_count !== 6'd26) begin bad++; $display("FAIL mid_pre_count got=%0d exp=26", free_count); end
    do_reset();
    total++; if (T_out !== 6'd32) begin bad++; $display("FAIL mid_T_out got=%0d exp=32", T_out); end
    total++; if (free_count !== 6'd32) begin bad++; $display("FAIL mid_count got=%0d exp=32", free_count); end
    dispatch = 1'b1;
    for (int i = 0; i < 32; i++) begin
      total++;
      if (T_out !== pr_tag_t'(32 + i)) begin bad++; $display("FAIL mid_seq[%0d] got=%0d exp=%0d", i, T_out, 32 + i); end
      cycle();
    end
    idle();
    total++; if (struct_hazard !== 1'b1) begin bad++; $display("FAIL mid_empty got=%0b exp=1", struct_hazard); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_drain();
    test_empty_push();
    test_overflow();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
